// File: rtl/dmem_arbiter_if.sv
// Signal bundle around dmem_arbiter: CPU data port, peripheral port and the RAM port.
// The arbiter takes the slave view. The requesters and the RAM take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              per_req;
    logic              per_we;
    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_wdata;
    logic              per_gnt;
    logic              per_rvalid;
    logic [DATA_W-1:0] per_rdata;

    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  per_req, per_we, per_addr, per_wdata,
        output per_gnt, per_rvalid, per_rdata,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output per_req, per_we, per_addr, per_wdata,
        input  per_gnt, per_rvalid, per_rdata,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, and the peripheral gets a forced slot
// after MAX_WAIT consecutive denied cycles. Read data returns one cycle after the grant.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_PER  = 2'd2;

    localparam logic [0:0] MODE_CPU_PRI   = 1'b0;
    localparam logic [0:0] MODE_PER_FORCE = 1'b1;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        rd_owner_q, rd_owner_d;
    logic [0:0]        arb_mode;
    logic              cpu_win;
    logic              per_win;

    // Grants are combinational and gated by reset, so nothing reaches the RAM while reset is held.
    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin : arbitrate
        arb_mode = (wait_cnt_q >= WAIT_MAX) ? MODE_PER_FORCE : MODE_CPU_PRI;
        cpu_win  = 1'b0;
        per_win  = 1'b0;
        if (reset) begin
            if (bus.cpu_req && bus.per_req) begin
                per_win = (arb_mode == MODE_PER_FORCE);
                cpu_win = (arb_mode == MODE_CPU_PRI);
            end else begin
                cpu_win = bus.cpu_req;
                per_win = bus.per_req;
            end
        end
        bus.cpu_gnt = cpu_win;
        bus.per_gnt = per_win;
    end

    always_comb begin : ram_mux
        bus.ram_wEn    = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_dataIn = '0;
        if (cpu_win) begin
            bus.ram_wEn    = bus.cpu_we;
            bus.ram_addr   = bus.cpu_addr;
            bus.ram_dataIn = bus.cpu_wdata;
        end else if (per_win) begin
            bus.ram_wEn    = bus.per_we;
            bus.ram_addr   = bus.per_addr;
            bus.ram_dataIn = bus.per_wdata;
        end
    end

    // The starvation count only runs while the peripheral is requesting and losing.
    always_comb begin : next_state
        wait_cnt_d = wait_cnt_q;
        if (!bus.per_req || per_win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        rd_owner_d = OWN_NONE;
        if (cpu_win && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (per_win && !bus.per_we) begin
            rd_owner_d = OWN_PER;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // The RAM data bus is steered to whichever port issued the read in the previous cycle.
    always_comb begin : read_return
        bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
        bus.per_rvalid = (rd_owner_q == OWN_PER);
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_dataOut : '0;
        bus.per_rdata  = bus.per_rvalid ? bus.ram_dataOut : '0;
    end

    grant_onehot: assert property (@(posedge clock) disable iff (!reset)
        !(bus.cpu_gnt && bus.per_gnt));

    grant_needs_req: assert property (@(posedge clock) disable iff (!reset)
        (!bus.cpu_gnt || bus.cpu_req) && (!bus.per_gnt || bus.per_req));

    wait_bounded: assert property (@(posedge clock) disable iff (!reset)
        wait_cnt_q <= WAIT_MAX);

    owner_legal: assert property (@(posedge clock) disable iff (!reset)
        rd_owner_q != 2'd3);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for the multi-cycle cases,
// and constrained-random traffic checked against a transaction-level model with a RAM model.
module tb_dmem_arbiter;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int OBS_W    = 3 + ADDR_W + 3 * DATA_W + 2;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_CPU  = 2'd1;
    localparam logic [1:0] W_PER  = 2'd2;

    typedef struct {
        logic              cpu_req;
        logic              cpu_we;
        logic [ADDR_W-1:0] cpu_addr;
        logic [DATA_W-1:0] cpu_wdata;
        logic              per_req;
        logic              per_we;
        logic [ADDR_W-1:0] per_addr;
        logic [DATA_W-1:0] per_wdata;
        logic [1:0]        exp_win;
        logic              exp_crv;
        logic [DATA_W-1:0] exp_crd;
        logic              exp_prv;
        logic [DATA_W-1:0] exp_prd;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Synchronous single-port RAM: inputs captured just before the edge, data out one cycle later.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        logic              cap_we;
        logic [ADDR_W-1:0] cap_addr;
        logic [DATA_W-1:0] cap_din;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        bus.ram_dataOut = '0;
        forever begin
            @(negedge clock);
            #4;
            cap_we   = bus.ram_wEn;
            cap_addr = bus.ram_addr;
            cap_din  = bus.ram_dataIn;
            @(posedge clock);
            #1;
            bus.ram_dataOut = mem[cap_addr];
            if (cap_we) mem[cap_addr] = cap_din;
        end
    end

    // Transaction-level reference: denial streak, pending read response, and memory contents.
    int                streak = 0;
    logic [1:0]        pend_who = W_NONE;
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] ref_mem [int];
    logic [1:0]        last_gnt;

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    function automatic logic [1:0] model_winner(input logic cr, input logic pr);
        if (cr && pr) return (streak >= MAX_WAIT) ? W_PER : W_CPU;
        if (cr) return W_CPU;
        if (pr) return W_PER;
        return W_NONE;
    endfunction

    task automatic model_commit(input vec_t v, input logic [1:0] win);
        if (v.per_req && win != W_PER) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
        else streak = 0;
        pend_who  = W_NONE;
        pend_data = '0;
        if (win == W_CPU) begin
            if (v.cpu_we) ref_mem[int'(v.cpu_addr)] = v.cpu_wdata;
            else begin pend_who = W_CPU; pend_data = ref_read(v.cpu_addr); end
        end else if (win == W_PER) begin
            if (v.per_we) ref_mem[int'(v.per_addr)] = v.per_wdata;
            else begin pend_who = W_PER; pend_data = ref_read(v.per_addr); end
        end
    endtask

    task automatic model_reset();
        streak    = 0;
        pend_who  = W_NONE;
        pend_data = '0;
    endtask

    function automatic logic [OBS_W-1:0] observe();
        return {bus.cpu_gnt, bus.per_gnt, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn,
                bus.cpu_rvalid, bus.cpu_rdata, bus.per_rvalid, bus.per_rdata};
    endfunction

    task automatic check(input string name, input logic [OBS_W-1:0] act, input logic [OBS_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.cpu_req   = v.cpu_req;
        bus.cpu_we    = v.cpu_we;
        bus.cpu_addr  = v.cpu_addr;
        bus.cpu_wdata = v.cpu_wdata;
        bus.per_req   = v.per_req;
        bus.per_we    = v.per_we;
        bus.per_addr  = v.per_addr;
        bus.per_wdata = v.per_wdata;
    endtask

    function automatic vec_t mk(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                                input logic [DATA_W-1:0] cd, input logic pr, input logic pw,
                                input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                                input logic [1:0] win, input logic crv, input logic [DATA_W-1:0] crd,
                                input logic prv, input logic [DATA_W-1:0] prd);
        vec_t v;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.per_req = pr; v.per_we = pw; v.per_addr = pa; v.per_wdata = pd;
        v.exp_win = win; v.exp_crv = crv; v.exp_crd = crd; v.exp_prv = prv; v.exp_prd = prd;
        return v;
    endfunction

    // One clock: drive at the falling edge, compare 1 ns later, then advance the model at the rising edge.
    task automatic run_cycle(input vec_t v, input bit from_table, input string name);
        logic [1:0]        win;
        logic              crv, prv, ew;
        logic [DATA_W-1:0] crd, prd, ed;
        logic [ADDR_W-1:0] ea;
        @(negedge clock);
        drive(v);
        #1;
        win = model_winner(v.cpu_req, v.per_req);
        crv = (pend_who == W_CPU);
        prv = (pend_who == W_PER);
        crd = crv ? pend_data : '0;
        prd = prv ? pend_data : '0;
        if (from_table) begin
            win = v.exp_win; crv = v.exp_crv; crd = v.exp_crd; prv = v.exp_prv; prd = v.exp_prd;
        end
        ew = 1'b0; ea = '0; ed = '0;
        if (win == W_CPU) begin ew = v.cpu_we; ea = v.cpu_addr; ed = v.cpu_wdata; end
        else if (win == W_PER) begin ew = v.per_we; ea = v.per_addr; ed = v.per_wdata; end
        last_gnt = {bus.cpu_gnt, bus.per_gnt};
        check(name, observe(), {win == W_CPU, win == W_PER, ew, ea, ed, crv, crd, prv, prd});
        win = model_winner(v.cpu_req, v.per_req);
        @(posedge clock);
        model_commit(v, win);
    endtask

    // Both ports held requesting; the observed grant sequence must match pat (C = CPU, P = peripheral).
    task automatic run_pattern(input string name, input string pat, input vec_t base);
        logic [39:0] act, exp;
        act = '0;
        exp = '0;
        for (int i = 0; i < pat.len(); i++) begin
            run_cycle(base, 1'b0, name);
            act = {act[37:0], last_gnt};
            exp = {exp[37:0], (pat[i] == "C") ? 2'b10 : 2'b01};
        end
        check({name, "_pattern"}, OBS_W'(act), OBS_W'(exp));
    endtask

    vec_t tbl [11];

    initial begin
        vec_t        v, both, idle;
        logic [1:0]  win;
        bit          c_hold, p_hold;

        idle = mk(0, 0, '0, '0, 0, 0, '0, '0, W_NONE, 0, '0, 0, '0);
        both = mk(1, 0, 12'h010, '0, 1, 0, 12'h002, '0, W_NONE, 0, '0, 0, '0);

        tbl[0]  = mk(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,        W_CPU,  0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(1, 1, 12'h001, 32'hA5A50001, 0, 0, 12'h000, 32'h0,        W_CPU,  0, 32'h0,        0, 32'h0);
        tbl[2]  = mk(0, 0, 12'h000, 32'h0,        1, 1, 12'h002, 32'h5A5A0002, W_PER,  0, 32'h0,        0, 32'h0);
        tbl[3]  = mk(1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        W_CPU,  0, 32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        W_NONE, 1, 32'hDEADBEEF, 0, 32'h0);
        tbl[5]  = mk(1, 1, 12'h0FF, 32'h12345678, 0, 0, 12'h000, 32'h0,        W_CPU,  0, 32'h0,        0, 32'h0);
        tbl[6]  = mk(0, 0, 12'h000, 32'h0,        1, 0, 12'h0FF, 32'h0,        W_PER,  0, 32'h0,        0, 32'h0);
        tbl[7]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        W_NONE, 0, 32'h0,        1, 32'h12345678);
        tbl[8]  = mk(1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,        W_CPU,  0, 32'h0,        0, 32'h0);
        tbl[9]  = mk(0, 0, 12'h000, 32'h0,        1, 0, 12'h002, 32'h0,        W_PER,  1, 32'hA5A50001, 0, 32'h0);
        tbl[10] = mk(0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        W_NONE, 0, 32'h0,        1, 32'h5A5A0002);

        // Reset held with both ports requesting: every output must read zero.
        drive(both);
        repeat (2) @(negedge clock);
        #1;
        check("reset_state", observe(), '0);
        drive(idle);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

        run_pattern("contention", "CCCCPCCCCP", both);

        // Peripheral backs off after three denials; the streak must restart from zero.
        repeat (3) run_cycle(both, 1'b0, "starve_build");
        v = both;
        v.per_req = 1'b0;
        run_cycle(v, 1'b0, "starve_drop");
        run_pattern("starve_clear", "CCCCP", both);

        // Reset lands between a CPU read grant and its response edge.
        repeat (2) run_cycle(both, 1'b0, "rst_build");
        @(negedge clock);
        drive(both);
        #1;
        check("rst_mid_gnt", OBS_W'({bus.cpu_gnt, bus.per_gnt}), OBS_W'(2'b10));
        #2;
        reset = 1'b0;
        #1;
        check("rst_outputs_low", observe(), '0);
        @(negedge clock);
        #1;
        check("rst_no_rvalid", observe(), '0);
        drive(idle);
        model_reset();
        #1;
        reset = 1'b1;
        run_pattern("post_reset", "CCCCP", both);

        c_hold = 1'b0;
        p_hold = 1'b0;
        v = idle;
        for (int i = 0; i < 400; i++) begin
            if (!c_hold) begin
                v.cpu_req   = ($urandom_range(0, 3) != 0);
                v.cpu_we    = 1'($urandom_range(0, 1));
                v.cpu_addr  = ADDR_W'($urandom_range(0, 15));
                v.cpu_wdata = $urandom;
            end
            if (!p_hold) begin
                v.per_req   = 1'($urandom_range(0, 1));
                v.per_we    = 1'($urandom_range(0, 1));
                v.per_addr  = ADDR_W'($urandom_range(0, 15));
                v.per_wdata = $urandom;
            end
            win = model_winner(v.cpu_req, v.per_req);
            run_cycle(v, 1'b0, "random");
            c_hold = v.cpu_req && (win != W_CPU);
            p_hold = v.per_req && (win != W_PER);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 200000");
        $fatal(1);
    end
endmodule
